// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array support blocks:
// deskew FSM state encoding and a constant-capable ceil(log2) helper.
package systolic_pkg;

   typedef enum logic [1:0] {
      DESKEW_STATE_IDLE    = 2'd0,
      DESKEW_STATE_COLLECT = 2'd1,
      DESKEW_STATE_DONE    = 2'd2
   } deskew_state_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned bits;
      bits = 0;
      for (int unsigned rem = value - 1; rem > 0; rem = rem >> 1) begin
         bits = bits + 1;
      end
      return bits;
   endfunction

endpackage

// File: rtl/deskew_lane.sv
// Fixed-depth word delay line for one deskew lane; DEPTH=0 degenerates
// to a wire so the last lane feeds the output stage directly.
module deskew_lane #(
   parameter int unsigned WORD_SIZE = 8,
   parameter int unsigned DEPTH     = 0
) (
   input  logic                 clk,
   input  logic                 clear,
   input  logic [WORD_SIZE-1:0] d,
   output logic [WORD_SIZE-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_clocking;
         assign unused_clocking = clk ^ clear;
         assign q = d;
      end else begin : g_reg
         logic [WORD_SIZE-1:0] stage [DEPTH];

         always_ff @(posedge clk or negedge clear) begin
            if (!clear) begin
               for (int unsigned i = 0; i < DEPTH; i++) begin
                  stage[i] <= '0;
               end
            end else begin
               stage[0] <= d;
               for (int unsigned i = 1; i < DEPTH; i++) begin
                  stage[i] <= stage[i-1];
               end
            end
         end

         assign q = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/systolic_deskew.sv
// Realigns staggered systolic-array column outputs into whole rows and counts
// rows per frame. Define DESKEW_ZERO_GATE_EN to zero out_data on non-valid cycles.
module systolic_deskew
   import systolic_pkg::*;
#(
   parameter int unsigned WORD_SIZE = 8,
   parameter int unsigned LANES     = 4,
   parameter int unsigned ROWS      = 4
) (
   input  logic                          clk,
   input  logic                          clear,
   input  logic                          start,
   input  logic [LANES*WORD_SIZE-1:0]    in_data,
   input  logic                          in_valid,
   output logic [LANES*WORD_SIZE-1:0]    out_data,
   output logic                          out_valid,
   output logic [clog2(ROWS+1)-1:0]      row_count,
   output logic                          busy,
   output logic                          frame_done
);

   localparam int unsigned DW = LANES * WORD_SIZE;
   localparam int unsigned CW = clog2(ROWS + 1);
   localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

   deskew_state_t state;
   logic [DW-1:0] aligned;
   logic [DW-1:0] next_data;
   logic          aligned_valid;
   logic          emit;

   // Lane 0 sits in the most significant word; lane k is delayed LANES-1-k cycles.
   genvar k;
   generate
      for (k = 0; k < LANES; k++) begin : g_lane
         deskew_lane #(
            .WORD_SIZE (WORD_SIZE),
            .DEPTH     (LANES - 1 - k)
         ) u_lane (
            .clk   (clk),
            .clear (clear),
            .d     (in_data[(LANES-1-k)*WORD_SIZE +: WORD_SIZE]),
            .q     (aligned[(LANES-1-k)*WORD_SIZE +: WORD_SIZE])
         );
      end
   endgenerate

   deskew_lane #(
      .WORD_SIZE (1),
      .DEPTH     (LANES - 1)
   ) u_valid (
      .clk   (clk),
      .clear (clear),
      .d     (in_valid),
      .q     (aligned_valid)
   );

   always_comb begin
      emit = (state == DESKEW_STATE_COLLECT) && aligned_valid;
`ifdef DESKEW_ZERO_GATE_EN
      next_data = emit ? aligned : '0;
`else
      next_data = aligned;
`endif
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state      <= DESKEW_STATE_IDLE;
         out_data   <= '0;
         out_valid  <= 1'b0;
         row_count  <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         out_data   <= next_data;
         out_valid  <= emit;
         frame_done <= 1'b0;
         case (state)
            DESKEW_STATE_IDLE: begin
               if (start) begin
                  state     <= DESKEW_STATE_COLLECT;
                  row_count <= '0;
                  busy      <= 1'b1;
               end
            end
            DESKEW_STATE_COLLECT: begin
               if (aligned_valid) begin
                  row_count <= row_count + 1'b1;
                  if (row_count == LAST_ROW) begin
                     frame_done <= 1'b1;
                     busy       <= 1'b0;
                     state      <= DESKEW_STATE_DONE;
                  end
               end
            end
            DESKEW_STATE_DONE: begin
               state <= DESKEW_STATE_IDLE;
            end
            default: begin
               state <= DESKEW_STATE_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_deskew.sv
// Self-checking bench for systolic_deskew (LANES=4, ROWS=2, WORD_SIZE=8):
// queue-based row model compared every cycle plus directed literal checks.
module tb_systolic_deskew;

   localparam int W  = 8;
   localparam int L  = 4;
   localparam int R  = 2;
   localparam int DW = L * W;
   localparam int CW = 2;
   localparam int PL = 16;

   logic          clk = 1'b0;
   logic          clear;
   logic          start;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic [CW-1:0] row_count;
   logic          busy;
   logic          frame_done;

   systolic_deskew #(
      .WORD_SIZE (W),
      .LANES     (L),
      .ROWS      (R)
   ) dut (
      .clk        (clk),
      .clear      (clear),
      .start      (start),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .row_count  (row_count),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   logic cmp_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
   endtask

   function automatic logic [W-1:0] lane_of(input logic [DW-1:0] w, input int k);
      return w[(L-1-k)*W +: W];
   endfunction

   // Reference model: per-cycle input history, rows framed by spec rules.
   logic [DW-1:0] hd[$];
   logic          hv[$];
   int            mst, mcount;
   logic [DW-1:0] m_al, e_data;
   logic          m_av, e_valid, e_fd, e_busy;
   int            e_rc;

   task automatic model_reset();
      hd = {};
      hv = {};
      for (int i = 0; i < L; i++) begin
         hd.push_back('0);
         hv.push_back(1'b0);
      end
      mst = 0; mcount = 0;
      e_data = '0; e_valid = 0; e_fd = 0; e_busy = 0; e_rc = 0;
   endtask

   always @(posedge clk or negedge clear) begin
      if (!clear) begin
         model_reset();
      end else begin
         hd.push_front(in_data);
         hv.push_front(in_valid);
         void'(hd.pop_back());
         void'(hv.pop_back());
         for (int k = 0; k < L; k++) m_al[(L-1-k)*W +: W] = lane_of(hd[L-1-k], k);
         m_av    = hv[L-1];
         e_valid = (mst == 1) && m_av;
         e_fd    = e_valid && (mcount == R - 1);
         case (mst)
            0: if (start) begin mst = 1; mcount = 0; end
            1: if (m_av) begin mcount++; if (mcount == R) mst = 2; end
            default: mst = 0;
         endcase
         e_busy = (mst == 1);
         e_rc   = mcount;
`ifdef DESKEW_ZERO_GATE_EN
         e_data = e_valid ? m_al : '0;
`else
         e_data = m_al;
`endif
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("out_valid",  32'(out_valid),  32'(e_valid));
         chk("frame_done", 32'(frame_done), 32'(e_fd));
         chk("busy",       32'(busy),       32'(e_busy));
         chk("row_count",  32'(row_count),  32'(e_rc));
         chk("out_data",   out_data,        e_data);
      end
   end

   // Plans are indexed by the cycle a row's lane-0 word enters.
   logic [DW-1:0] pw[PL];
   logic          pv[PL];
   logic          ps[PL];
   logic [DW-1:0] s_data[PL];
   logic          s_v[PL], s_fd[PL], s_busy[PL];
   logic [CW-1:0] s_rc[PL];

   task automatic plan_clear();
      for (int i = 0; i < PL; i++) begin
         pw[i] = $urandom; pv[i] = 1'b0; ps[i] = 1'b0;
      end
   endtask

   task automatic play(input int n);
      logic [DW-1:0] d;
      for (int t = 0; t < n; t++) begin
         for (int k = 0; k < L; k++) begin
            if (t - k >= 0) d[(L-1-k)*W +: W] = lane_of(pw[t-k], k);
            else            d[(L-1-k)*W +: W] = W'($urandom);
         end
         in_data  = d;
         in_valid = pv[t];
         start    = ps[t];
         @(posedge clk);
         #1;
         s_data[t] = out_data; s_v[t] = out_valid; s_fd[t] = frame_done;
         s_busy[t] = busy;     s_rc[t] = row_count;
      end
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   function automatic int count_v(input int n);
      int c = 0;
      for (int i = 0; i < n; i++) c += int'(s_v[i]);
      return c;
   endfunction

   function automatic int count_fd(input int n);
      int c = 0;
      for (int i = 0; i < n; i++) c += int'(s_fd[i]);
      return c;
   endfunction

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_data"}, out_data, 32'h0);
      chk({tag, "_valid"}, 32'(out_valid), 32'h0);
      chk({tag, "_rc"}, 32'(row_count), 32'h0);
      chk({tag, "_busy"}, 32'(busy), 32'h0);
      chk({tag, "_fd"}, 32'(frame_done), 32'h0);
   endtask

   initial begin
      clear = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
      #3 clear = 1'b0;
      #1 check_zero_outputs("reset");
      cmp_en = 1'b1;
      @(posedge clk); #1;
      #6 clear = 1'b1;
      @(posedge clk); #1;

      // Rows without start are dropped and not counted.
      plan_clear();
      for (int i = 0; i < 6; i++) pv[i] = 1'b1;
      play(10);
      chk("nostart_valid_cnt", 32'(count_v(10)), 32'd0);
      chk("nostart_rc", 32'(s_rc[9]), 32'd0);

      // Two staggered back-to-back rows form one frame.
      plan_clear();
      ps[0] = 1'b1;
      pv[1] = 1'b1; pw[1] = 32'h11223344;
      pv[2] = 1'b1; pw[2] = 32'hA1A2A3A4;
      play(8);
      chk("arm_busy", 32'(s_busy[0]), 32'd1);
      chk("arm_rc", 32'(s_rc[0]), 32'd0);
      chk("row1_data", s_data[4], 32'h11223344);
      chk("row1_valid", 32'(s_v[4]), 32'd1);
      chk("row1_rc", 32'(s_rc[4]), 32'd1);
      chk("row1_fd", 32'(s_fd[4]), 32'd0);
      chk("row2_data", s_data[5], 32'hA1A2A3A4);
      chk("row2_valid", 32'(s_v[5]), 32'd1);
      chk("row2_fd", 32'(s_fd[5]), 32'd1);
      chk("row2_rc", 32'(s_rc[5]), 32'd2);
      chk("row2_busy", 32'(s_busy[5]), 32'd0);
      chk("after_valid", 32'(s_v[6]), 32'd0);
      chk("after_rc", 32'(s_rc[6]), 32'd2);

      // start during COLLECT is ignored; third row lands in DONE and is dropped.
      plan_clear();
      ps[0] = 1'b1; ps[2] = 1'b1;
      pv[1] = 1'b1; pv[3] = 1'b1; pv[4] = 1'b1;
      play(10);
      chk("restart_fd_cnt", 32'(count_fd(10)), 32'd1);
      chk("restart_fd_at", 32'(s_fd[6]), 32'd1);
      chk("restart_drop", 32'(s_v[7]), 32'd0);
      chk("restart_rc", 32'(s_rc[9]), 32'd2);

      // Reset after one of two rows discards the frame.
      plan_clear();
      ps[0] = 1'b1; pv[1] = 1'b1; pv[2] = 1'b1;
      play(5);
      chk("partial_rc", 32'(s_rc[4]), 32'd1);
      #2 clear = 1'b0;
      #1 check_zero_outputs("midreset");
      #3 clear = 1'b1;
      plan_clear();
      for (int i = 0; i < 4; i++) pv[i] = 1'b0;
      play(4);
      chk("postreset_fd_cnt", 32'(count_fd(4)), 32'd0);
      plan_clear();
      ps[0] = 1'b1; pv[1] = 1'b1; pv[2] = 1'b1;
      play(8);
      chk("fresh_fd_cnt", 32'(count_fd(8)), 32'd1);
      chk("fresh_fd_at", 32'(s_fd[5]), 32'd1);

      // Gap between two rows.
      plan_clear();
      ps[0] = 1'b1;
      pv[1] = 1'b1; pw[1] = 32'h01020304;
      pv[2] = 1'b0; pw[2] = 32'hC0C1C2C3;
      pv[3] = 1'b1; pw[3] = 32'h0B0C0D0E;
      play(9);
      chk("gap_row1", s_data[4], 32'h01020304);
      chk("gap_valid", 32'(s_v[5]), 32'd0);
`ifdef DESKEW_ZERO_GATE_EN
      chk("gap_data", s_data[5], 32'h00000000);
`else
      chk("gap_data", s_data[5], 32'hC0C1C2C3);
`endif
      chk("gap_row2", s_data[6], 32'h0B0C0D0E);
      chk("gap_fd", 32'(s_fd[6]), 32'd1);

      // Random traffic with one asynchronous reset pulse.
      for (int i = 0; i < 500; i++) begin
         in_data  = $urandom;
         in_valid = 1'($urandom_range(0, 1));
         start    = ($urandom_range(0, 7) == 0);
         @(posedge clk); #1;
         if (i == 250) begin
            #2 clear = 1'b0;
            #4 clear = 1'b1;
         end
      end
      in_valid = 1'b0; start = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk); #1;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
